// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM encoding, digit
// geometry and the default operand width.
// Latency: n/a (types and constants only). Backpressure: n/a.
package bcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } arb_state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int DIGIT_W    = BCD_W / BCD_DIGITS;
    localparam int BIN_W_DEF  = 13;

    // Round-robin successor of a channel index, wrapping at n_ch.
    function automatic logic [2:0] next_ch(input logic [2:0] id, input int n_ch);
        return (int'(id) == n_ch - 1) ? 3'd0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: channel ptr has top priority, then
// ptr+1 and so on, wrapping. Latency: combinational. Backpressure: none.
// Ports: req (per-channel request), ptr (priority pointer, < N_CH),
//        gnt (one-hot winner), gnt_id (encoded winner), gnt_vld (any request).
module rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  logic [2:0]      ptr,
    output logic [N_CH-1:0] gnt,
    output logic [2:0]      gnt_id,
    output logic            gnt_vld
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [2:0]        off;
    logic [3:0]        sum;
    logic              found;

    // Rotate the request vector so that channel ptr lands on bit 0; the
    // first set bit is then the offset of the winner from ptr.
    assign req_dbl = {req, req};
    assign req_rot = N_CH'(req_dbl >> ptr);
    assign gnt_vld = |req;

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = 3'(k);
            end
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign gnt_id = (sum >= 4'(N_CH)) ? 3'(sum - 4'(N_CH)) : sum[2:0];

    always_comb begin
        gnt = '0;
        for (int j = 0; j < N_CH; j++) begin
            gnt[j] = gnt_vld && (gnt_id == 3'(j));
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among N_CH requesters, round-robin,
// storing each channel's four result digits in a held per-channel register.
// Latency: req -> ack/conv_start 1 cycle; conv_done_tick -> ch_done 1 cycle.
// Backpressure: grants only in IDLE with conv_ready high; requests simply wait.
// Ports: req/bin in, ack/ch_done/ch_bcd out per channel; busy, grant_id,
//        timeout_err status; conv_start/conv_bin out and conv_ready,
//        conv_done_tick, conv_bcd3..0 in towards the converter.
// Build option: define BCD_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise WAIT is unbounded and timeout_err is 0.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int BIN_W       = BIN_W_DEF,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*BIN_W-1:0]   bin,
    output logic [N_CH-1:0]         ack,
    output logic [N_CH-1:0]         ch_done,
    output logic [N_CH*BCD_W-1:0]   ch_bcd,
    output logic                    busy,
    output logic [2:0]              grant_id,
    output logic                    timeout_err,
    output logic                    conv_start,
    output logic [BIN_W-1:0]        conv_bin,
    input  logic                    conv_ready,
    input  logic                    conv_done_tick,
    input  logic [DIGIT_W-1:0]      conv_bcd3,
    input  logic [DIGIT_W-1:0]      conv_bcd2,
    input  logic [DIGIT_W-1:0]      conv_bcd1,
    input  logic [DIGIT_W-1:0]      conv_bcd0
);

    arb_state_t        state;
    logic [2:0]        ptr;
    logic [N_CH-1:0]   win_gnt;
    logic [2:0]        win_id;
    logic              win_vld;
    logic [BIN_W-1:0]  win_bin;
    logic [BCD_W-1:0]  digits;

    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (win_gnt),
        .gnt_id  (win_id),
        .gnt_vld (win_vld)
    );

    // AND-OR operand mux driven by the one-hot winner.
    always_comb begin
        win_bin = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (win_gnt[j]) begin
                win_bin = win_bin | bin[j*BIN_W +: BIN_W];
            end
        end
    end

    assign digits = {conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0};
    assign busy   = (state != ST_IDLE);

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            ack         <= '0;
            ch_done     <= '0;
            ch_bcd      <= '0;
            grant_id    <= '0;
            conv_start  <= 1'b0;
            conv_bin    <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            ack        <= '0;
            ch_done    <= '0;
            conv_start <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (win_vld && conv_ready) begin
                        grant_id   <= win_id;
                        conv_bin   <= win_bin;
                        conv_start <= 1'b1;
                        ack        <= win_gnt;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
`ifdef BCD_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The result register and ch_done are updated together on
                    // entry to STORE so ch_done always sees the new digits.
                    if (conv_done_tick) begin
                        for (int j = 0; j < N_CH; j++) begin
                            if (grant_id == 3'(j)) begin
                                ch_bcd[j*BCD_W +: BCD_W] <= digits;
                                ch_done[j]               <= 1'b1;
                            end
                        end
                        state <= ST_STORE;
                    end
`ifdef BCD_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= next_ch(grant_id, N_CH);
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_STORE: begin
                    ptr   <= next_ch(grant_id, N_CH);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;
    localparam int N   = 4;
    localparam int BW  = 13;
    localparam int TOC = 32;
`ifdef BCD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [BW-1:0]     opnd [N];
    logic [N*BW-1:0]   bin;
    logic [N-1:0]      ack, ch_done;
    logic [N*16-1:0]   ch_bcd;
    logic              busy, timeout_err, conv_start;
    logic [2:0]        grant_id;
    logic [BW-1:0]     conv_bin;
    logic              conv_ready, conv_done_tick;
    logic [3:0]        conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0;

    int checks = 0;
    int failures = 0;

    // converter stub controls
    int   stub_lat = 2;
    logic stub_hang = 1'b0;
    logic hold_ready = 1'b0;
    logic spur = 1'b0;

    always #5 clk = ~clk;

    assign bin = {opnd[3], opnd[2], opnd[1], opnd[0]};

    bcd_conv_arbiter #(.N_CH(N), .BIN_W(BW), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .reset(reset), .req(req), .bin(bin), .ack(ack),
        .ch_done(ch_done), .ch_bcd(ch_bcd), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err), .conv_start(conv_start), .conv_bin(conv_bin),
        .conv_ready(conv_ready), .conv_done_tick(conv_done_tick),
        .conv_bcd3(conv_bcd3), .conv_bcd2(conv_bcd2),
        .conv_bcd1(conv_bcd1), .conv_bcd0(conv_bcd0)
    );

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[2'(c)]) return c;
        end
        return -1;
    endfunction

    // Converter stub: latches the operand on start, answers after stub_lat
    // cycles; digit lines carry junk except in the completion cycle.
    logic        cbusy;
    int          ccnt;
    logic [BW-1:0] cval;
    logic        stub_tick;
    logic [15:0] cdig;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cbusy <= 1'b0; ccnt <= 0; cval <= '0; stub_tick <= 1'b0; cdig <= '0;
        end else begin
            stub_tick <= 1'b0;
            cdig      <= 16'($urandom);
            if (cbusy) begin
                if (ccnt > 0) ccnt <= ccnt - 1;
                else if (!stub_hang) begin
                    stub_tick <= 1'b1;
                    cdig      <= bcd16(int'(cval));
                    cbusy     <= 1'b0;
                end
            end else if (conv_start) begin
                cbusy <= 1'b1;
                cval  <= conv_bin;
                ccnt  <= stub_lat;
            end
        end
    end
    assign conv_ready     = !cbusy && !hold_ready;
    assign conv_done_tick = stub_tick | spur;
    assign {conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0} = cdig;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; spur = 1'b0; hold_ready = 1'b0; stub_hang = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input logic [N-1:0] mask, input string tag);
        int n = 0;
        while (!(|(ack & mask)) && n < 300) begin tick(); n++; end
        check({tag, "_ack_in_time"}, 64'(n < 300), 64'd1);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (!conv_done_tick && n < 300) begin tick(); n++; end
        check({tag, "_tick_in_time"}, 64'(n < 300), 64'd1);
    endtask

    task automatic wait_chdone(input logic [N-1:0] mask, input string tag);
        int n = 0;
        while (!(|(ch_done & mask)) && n < 300) begin tick(); n++; end
        check({tag, "_done_in_time"}, 64'(n < 300), 64'd1);
    endtask

    // Transaction-level reference model, sampled mid-cycle.
    logic          m_out;
    int            m_ch, m_ptr, m_age;
    logic [BW-1:0] m_val;
    logic [15:0]   m_bcd [N];
    logic          p_idle, p_ready, p_tick, p_start;
    logic [N-1:0]  p_req;
    logic [BW-1:0] p_opnd [N];

    always @(negedge clk) begin
        int   w;
        logic exp_done, exp_to;
        if (reset) begin
            m_out = 1'b0; m_ch = 0; m_ptr = 0; m_age = 0; m_val = '0;
            for (int i = 0; i < N; i++) begin m_bcd[2'(i)] = '0; p_opnd[2'(i)] = '0; end
            p_idle = 1'b1; p_ready = 1'b0; p_tick = 1'b0; p_start = 1'b0; p_req = '0;
        end else begin
            if (m_out) m_age++;
            exp_done = p_tick && m_out;
            exp_to   = TO_EN && m_out && !exp_done && (m_age == TOC + 1);
            check("m_grant_when_due", 64'(ack != 0), 64'(p_idle && (p_req != 0) && p_ready));
            check("m_start_eq_ack", 64'(conv_start), 64'(ack != 0));
            check("m_start_not_back2back", 64'(p_start && conv_start), 64'd0);
            if (ack != 0) begin
                w = rr_pick(p_req, m_ptr);
                if (w < 0) w = 0;
                check("m_ack_winner", 64'(ack), 64'd1 << w);
                check("m_grant_id", 64'(grant_id), 64'(w));
                check("m_conv_bin", 64'(conv_bin), 64'(p_opnd[2'(w)]));
                m_out = 1'b1; m_ch = w; m_val = p_opnd[2'(w)]; m_age = 0;
            end
            check("m_ch_done", 64'(ch_done), exp_done ? (64'd1 << m_ch) : 64'd0);
            check("m_timeout", 64'(timeout_err), 64'(exp_to));
            if (exp_done) begin
                m_bcd[2'(m_ch)] = bcd16(int'(m_val));
                m_ptr = (m_ch + 1) % N;
                m_out = 1'b0;
            end
            if (exp_to) begin
                m_ptr = (m_ch + 1) % N;
                m_out = 1'b0;
            end
            check("m_busy", 64'(busy), 64'(m_out || exp_done));
            check("m_ch_bcd", 64'(ch_bcd), {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]});
            p_idle  = !m_out && !exp_done;
            p_req   = req;
            p_ready = conv_ready;
            p_tick  = conv_done_tick;
            p_start = conv_start;
            for (int i = 0; i < N; i++) p_opnd[2'(i)] = opnd[2'(i)];
        end
    end

    initial begin
        int n, got;
        logic [N-1:0] acc;
        logic saw;
        for (int i = 0; i < N; i++) opnd[2'(i)] = '0;

        // reset values
        tick();
        check("rst_outputs", 64'({ack, ch_done, busy, grant_id, timeout_err, conv_start, conv_bin}), 64'd0);
        check("rst_ch_bcd", 64'(ch_bcd), 64'd0);
        reset = 1'b0;
        tick();

        // single request on ch2
        opnd[2] = 13'd4095; req[2] = 1'b1;
        tick();
        check("single_ack", 64'(ack), 64'b0100);
        check("single_conv_bin", 64'(conv_bin), 64'd4095);
        check("single_grant_id", 64'(grant_id), 64'd2);
        req[2] = 1'b0;
        wait_tick("single");
        tick();
        check("single_ch_done", 64'(ch_done), 64'b0100);
        check("single_ch_bcd", 64'(ch_bcd), 64'h0000_4095_0000_0000);

        // a completion pulse while idle is ignored
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_no_done", 64'(ch_done), 64'd0);
        check("spur_idle", 64'(busy), 64'd0);

        // all four at once: 0,1,2,3
        do_reset();
        opnd[0] = 13'd1; opnd[1] = 13'd22; opnd[2] = 13'd333; opnd[3] = 13'd8191;
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_ack(4'b1111, "all");
            got = -1;
            for (int i = 0; i < N; i++) if (ack[2'(i)]) got = i;
            check("all_order", 64'(got), 64'(k));
            if (got >= 0) req[2'(got)] = 1'b0;
            tick();
        end
        wait_chdone(4'b1000, "all");
        check("all_ch_bcd", 64'(ch_bcd), 64'h8191_0333_0022_0001);

        // fairness: after ch1, ch3 beats ch0
        do_reset();
        opnd[1] = 13'd7; req[1] = 1'b1;
        tick();
        check("fair_ack1", 64'(ack), 64'b0010);
        req[1] = 1'b0;
        wait_chdone(4'b0010, "fair1");
        opnd[0] = 13'd10; opnd[3] = 13'd3000; req = 4'b1001;
        wait_ack(4'b1001, "fair");
        check("fair_ch3_first", 64'(ack), 64'b1000);
        req[3] = 1'b0;
        tick();
        wait_ack(4'b0001, "fair0");
        check("fair_ch0_next", 64'(ack), 64'b0001);
        req[0] = 1'b0;
        wait_chdone(4'b0001, "fair0");

        // conv_ready low blocks the grant without losing the request
        hold_ready = 1'b1; opnd[1] = 13'd555; req[1] = 1'b1;
        acc = '0;
        repeat (6) begin tick(); acc = acc | ack; end
        check("blocked_no_ack", 64'(acc), 64'd0);
        hold_ready = 1'b0;
        tick();
        check("unblocked_ack", 64'(ack), 64'b0010);
        req[1] = 1'b0;
        wait_chdone(4'b0010, "blocked");

        // req held through ch_done: next start at d+3
        opnd[0] = 13'd42; req[0] = 1'b1;
        wait_ack(4'b0001, "hold");
        wait_tick("hold");
        tick();
        check("hold_done_d1", 64'(ch_done), 64'b0001);
        n = 1;
        while (!conv_start && n < 20) begin tick(); n++; end
        check("hold_restart_d3", 64'(n), 64'd3);
        check("hold_reack", 64'(ack), 64'b0001);
        req[0] = 1'b0;
        wait_chdone(4'b0001, "hold2");

        // reset while waiting, then service restarts from ptr 0
        stub_lat = 40; opnd[2] = 13'd77; req[2] = 1'b1;
        wait_ack(4'b0100, "rstw");
        req[2] = 1'b0;
        repeat (3) tick();
        check("rstw_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rstw_outputs", 64'({ack, ch_done, busy, grant_id, timeout_err, conv_start, conv_bin}), 64'd0);
        check("rstw_ch_bcd", 64'(ch_bcd), 64'd0);
        tick();
        reset = 1'b0;
        stub_lat = 1; opnd[0] = 13'd9; opnd[2] = 13'd99; req = 4'b0101;
        wait_ack(4'b0101, "rstw2");
        check("rstw_ptr0", 64'(ack), 64'b0001);
        req[0] = 1'b0;
        tick();
        wait_ack(4'b0100, "rstw3");
        check("rstw_ch2_next", 64'(ack), 64'b0100);
        req[2] = 1'b0;
        wait_chdone(4'b0100, "rstw3");

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            stub_lat   = $urandom_range(0, 6);
            hold_ready = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[2'(i)] && ack[2'(i)]) begin
                    if ($urandom_range(0, 1) == 0) req[2'(i)] = 1'b0;
                    else opnd[2'(i)] = 13'($urandom_range(0, 8191));
                end else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
                    opnd[2'(i)] = 13'($urandom_range(0, 8191));
                    req[2'(i)]  = 1'b1;
                end
            end
            tick();
        end
        req = '0; hold_ready = 1'b0;
        repeat (60) tick();
        check("drain_idle", 64'(busy), 64'd0);

        // converter that never completes
        stub_lat = 0; stub_hang = 1'b1; opnd[1] = 13'd100; req[1] = 1'b1;
        wait_ack(4'b0010, "hang");
        req[1] = 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
        n = 0; saw = 1'b0;
        while (!timeout_err && n < 100) begin
            tick(); n++;
            if (ch_done != 0) saw = 1'b1;
        end
        check("to_latency", 64'(n), 64'(TOC + 1));
        check("to_no_done", 64'(saw), 64'd0);
        check("to_idle", 64'(busy), 64'd0);
        tick();
        check("to_single_pulse", 64'(timeout_err), 64'd0);
`else
        saw = 1'b0;
        repeat (100) begin
            tick();
            if (timeout_err) saw = 1'b1;
        end
        check("hang_busy", 64'(busy), 64'd1);
        check("hang_no_timeout", 64'(saw), 64'd0);
`endif
        do_reset();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
